mem_stage: RTL and testbench

- Pipeline memory stage: an EX/MEM stage register plus a data-memory access controller.
- Captures execute-stage results and issues load/store requests over a req/ack handshake to data memory.
- Stalls upstream while an access is outstanding.
- Presents completed results on mem_* outputs, which feed the MEM/WB stage combinationally.
- Non-memory instructions pass through with one-cycle latency.

---
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM stage register plus a req/ack data-memory access controller.
// Optional build macro MEM_ALIGN_CHECK_EN: a captured mem op to an odd address
// skips the memory request and completes straight away with mem_err.
module mem_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_W   = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_regWrite,
  input  logic [1:0]        ex_memToReg,
  input  logic [REG_W-1:0]  ex_write_reg,
  input  logic              ex_memRead,
  input  logic              ex_memWrite,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic [DATA_W-1:0] ex_pc_plus,
  input  logic [DATA_W-1:0] ex_sign_ext_low_bits,
  input  logic              flush,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_wr,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_regWrite,
  output logic [1:0]        mem_memToReg,
  output logic [REG_W-1:0]  mem_write_reg,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic [DATA_W-1:0] mem_pc_plus,
  output logic [DATA_W-1:0] mem_sign_ext_low_bits,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              mem_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter only needs to reach TIMEOUT-1; the TIMEOUT-th idle cycle aborts.
  localparam int unsigned CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_capture;
  logic              w_load_rdata;
  logic              w_cap_valid;
  logic              w_cap_memop;
  logic              w_misalign;
  logic              w_to_hit;

  logic              r_valid;
  logic              r_regWrite;
  logic              r_memRead;
  logic              r_memWrite;
  logic [1:0]        r_memToReg;
  logic [REG_W-1:0]  r_write_reg;
  logic [DATA_W-1:0] r_alu_out;
  logic [DATA_W-1:0] r_write_data;
  logic [DATA_W-1:0] r_pc_plus;
  logic [DATA_W-1:0] r_sign_ext;
  logic [DATA_W-1:0] r_read_data;

  assign w_cap_valid = ex_valid & ~flush;
  assign w_cap_memop = w_cap_valid & (ex_memRead | ex_memWrite);
  assign w_to_hit    = (TIMEOUT != 0) && (r_cnt == CNT_W'(TO_LAST));

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = ex_alu_out[0];
`else
  assign w_misalign = 1'b0;
`endif

  // Next-state, capture enable, timeout counter and error pulse decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_err_nxt    = 1'b0;
    w_capture    = 1'b0;
    w_load_rdata = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_capture = 1'b1;
        w_cnt_nxt = '0;
        if (w_cap_memop && w_misalign) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end else if (w_cap_memop) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          w_state_nxt  = S_DONE;
          w_cnt_nxt    = '0;
          w_load_rdata = r_memRead & ~r_memWrite;
        end else if (w_to_hit) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Controller state, timeout counter and error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // EX/MEM stage register; holds while an access is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= 1'b0;
      r_regWrite   <= 1'b0;
      r_memRead    <= 1'b0;
      r_memWrite   <= 1'b0;
      r_memToReg   <= '0;
      r_write_reg  <= '0;
      r_alu_out    <= '0;
      r_write_data <= '0;
      r_pc_plus    <= '0;
      r_sign_ext   <= '0;
    end else if (w_capture) begin
      r_valid      <= w_cap_valid;
      r_regWrite   <= w_cap_valid & ex_regWrite;
      r_memRead    <= w_cap_valid & ex_memRead;
      r_memWrite   <= w_cap_valid & ex_memWrite;
      r_memToReg   <= ex_memToReg;
      r_write_reg  <= ex_write_reg;
      r_alu_out    <= ex_alu_out;
      r_write_data <= ex_write_data;
      r_pc_plus    <= ex_pc_plus;
      r_sign_ext   <= ex_sign_ext_low_bits;
    end
  end

  // Load data latch, written only when a load is acknowledged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_read_data <= '0;
    end else if (w_load_rdata) begin
      r_read_data <= dmem_rdata;
    end
  end

  assign stall_out             = (r_state == S_WAIT);
  assign dmem_req              = (r_state == S_WAIT);
  assign dmem_wr               = r_memWrite;
  assign dmem_addr             = r_alu_out;
  assign dmem_wdata            = r_write_data;
  assign mem_regWrite          = r_valid & r_regWrite & (r_state != S_WAIT) & ~r_err;
  assign mem_memToReg          = r_memToReg;
  assign mem_write_reg         = r_write_reg;
  assign mem_alu_out           = r_alu_out;
  assign mem_pc_plus           = r_pc_plus;
  assign mem_sign_ext_low_bits = r_sign_ext;
  assign mem_read_data         = r_read_data;
  assign mem_err               = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model.
module tb_mem_stage;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned TIMEOUT = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid, ex_regWrite, ex_memRead, ex_memWrite, flush;
  logic [1:0]        ex_memToReg;
  logic [REG_W-1:0]  ex_write_reg;
  logic [DATA_W-1:0] ex_alu_out, ex_write_data, ex_pc_plus, ex_sign_ext_low_bits;
  logic              stall_out, dmem_req, dmem_wr, dmem_ack, mem_regWrite, mem_err;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [1:0]        mem_memToReg;
  logic [REG_W-1:0]  mem_write_reg;
  logic [DATA_W-1:0] mem_alu_out, mem_pc_plus, mem_sign_ext_low_bits, mem_read_data;

  mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_memToReg(ex_memToReg),
    .ex_write_reg(ex_write_reg), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_alu_out(ex_alu_out), .ex_write_data(ex_write_data), .ex_pc_plus(ex_pc_plus),
    .ex_sign_ext_low_bits(ex_sign_ext_low_bits), .flush(flush),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_wr(dmem_wr),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_regWrite(mem_regWrite), .mem_memToReg(mem_memToReg),
    .mem_write_reg(mem_write_reg), .mem_alu_out(mem_alu_out), .mem_pc_plus(mem_pc_plus),
    .mem_sign_ext_low_bits(mem_sign_ext_low_bits), .mem_read_data(mem_read_data),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Instruction held by the stage, as the model sees it.
  typedef struct {
    logic              v, rw, rd, wrt;
    logic [1:0]        m2r;
    logic [REG_W-1:0]  wr;
    logic [DATA_W-1:0] alu, wd, pc, se;
  } inst_t;

  inst_t             held;
  bit                m_wait;     // request outstanding
  bit                m_err;      // current completion was an abort
  int                m_waited;   // request cycles already spent
  int                lat;        // request cycle in which the responder acks
  logic [DATA_W-1:0] m_rdata;
  bit                model_on = 1'b0;
  int                n_req = 0;

  task automatic model_reset();
    held     = '{default: '0};
    m_wait   = 1'b0;
    m_err    = 1'b0;
    m_waited = 0;
    m_rdata  = '0;
  endtask

  // Advance the model across one clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (m_wait) begin
      m_waited++;
      if (dmem_ack) begin
        m_wait = 1'b0;
        if (held.rd && !held.wrt) m_rdata = dmem_rdata;
      end else if (TIMEOUT != 0 && m_waited == int'(TIMEOUT)) begin
        m_wait = 1'b0;
        m_err  = 1'b1;
      end
    end else begin
      held.v   = ex_valid & ~flush;
      held.rw  = held.v & ex_regWrite;
      held.rd  = held.v & ex_memRead;
      held.wrt = held.v & ex_memWrite;
      held.m2r = ex_memToReg;
      held.wr  = ex_write_reg;
      held.alu = ex_alu_out;
      held.wd  = ex_write_data;
      held.pc  = ex_pc_plus;
      held.se  = ex_sign_ext_low_bits;
      m_err    = 1'b0;
      if (held.rd || held.wrt) begin
        if (ALIGN && held.alu[0]) begin
          m_err = 1'b1;
        end else begin
          m_wait   = 1'b1;
          m_waited = 0;
          lat      = int'($urandom_range(0, 5));
          n_req++;
        end
      end
    end
  endtask

  // Compare every DUT output with the model once per cycle.
  always @(negedge clk) begin
    if (model_on) begin
      check("stall_out", 32'(stall_out), 32'(m_wait));
      check("dmem_req", 32'(dmem_req), 32'(m_wait));
      check("dmem_wr", 32'(dmem_wr), 32'(held.wrt));
      check("dmem_addr", 32'(dmem_addr), 32'(held.alu));
      check("dmem_wdata", 32'(dmem_wdata), 32'(held.wd));
      check("mem_regWrite", 32'(mem_regWrite), 32'(held.v & held.rw & ~m_wait & ~m_err));
      check("mem_memToReg", 32'(mem_memToReg), 32'(held.m2r));
      check("mem_write_reg", 32'(mem_write_reg), 32'(held.wr));
      check("mem_alu_out", 32'(mem_alu_out), 32'(held.alu));
      check("mem_pc_plus", 32'(mem_pc_plus), 32'(held.pc));
      check("mem_sign_ext", 32'(mem_sign_ext_low_bits), 32'(held.se));
      check("mem_read_data", 32'(mem_read_data), 32'(m_rdata));
      check("mem_err", 32'(mem_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic rd, input logic wrt,
                        input logic [REG_W-1:0] wr, input logic [DATA_W-1:0] alu,
                        input logic [DATA_W-1:0] wd);
    ex_valid             = v;
    ex_regWrite          = rw;
    ex_memRead           = rd;
    ex_memWrite          = wrt;
    ex_write_reg         = wr;
    ex_alu_out           = alu;
    ex_write_data        = wd;
    ex_memToReg          = 2'($urandom_range(0, 3));
    ex_pc_plus           = DATA_W'($urandom);
    ex_sign_ext_low_bits = DATA_W'($urandom);
  endtask

  task automatic drive_random();
    int kind;
    kind = int'($urandom_range(0, 4));
    set_ex($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
           kind == 0 || kind == 2, kind == 1 || kind == 2,
           REG_W'($urandom), DATA_W'($urandom), DATA_W'($urandom));
    flush      = ($urandom_range(0, 7) == 0);
    dmem_rdata = DATA_W'($urandom);
    if (m_wait) dmem_ack = (m_waited == lat);
    else        dmem_ack = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    rst = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    ex_memToReg = '0; ex_pc_plus = '0; ex_sign_ext_low_bits = '0;
    flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall_out), 32'h0);
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_regWrite", 32'(mem_regWrite), 32'h0);
    check("rst_alu_out", 32'(mem_alu_out), 32'h0);
    check("rst_read_data", 32'(mem_read_data), 32'h0);
    check("rst_err", 32'(mem_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ALU op: one-cycle latency
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h1234, 16'h0);
    tick();
    model_on = 1'b1;
    check("alu_regWrite", 32'(mem_regWrite), 32'h1);
    check("alu_write_reg", 32'(mem_write_reg), 32'h3);
    check("alu_out", 32'(mem_alu_out), 32'h1234);
    check("alu_stall", 32'(stall_out), 32'h0);
    check("alu_req", 32'(dmem_req), 32'h0);

    // Load 0x0040, ack in third request cycle; ex inputs change meanwhile
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 16'h0040, 16'h0);
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 16'h9999, 16'h0);
    for (int i = 0; i < 3; i++) begin
      check("ld_stall", 32'(stall_out), 32'h1);
      check("ld_req", 32'(dmem_req), 32'h1);
      check("ld_addr", 32'(dmem_addr), 32'h0040);
      check("ld_regWrite_wait", 32'(mem_regWrite), 32'h0);
      if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 16'hBEEF; end
      tick();
    end
    dmem_ack = 1'b0;
    check("ld_read_data", 32'(mem_read_data), 32'hBEEF);
    check("ld_regWrite_done", 32'(mem_regWrite), 32'h1);
    check("ld_hold_alu", 32'(mem_alu_out), 32'h0040);
    check("ld_done_stall", 32'(stall_out), 32'h0);

    // Store 0x0010 / 0xA5A5, ack in first request cycle, back-to-back ALU op
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0010, 16'hA5A5);
    tick();
    check("st_req", 32'(dmem_req), 32'h1);
    check("st_wr", 32'(dmem_wr), 32'h1);
    check("st_wdata", 32'(dmem_wdata), 32'hA5A5);
    dmem_ack = 1'b1; dmem_rdata = 16'h7777;
    tick();
    dmem_ack = 1'b0;
    check("st_done_req", 32'(dmem_req), 32'h0);
    check("st_read_data_kept", 32'(mem_read_data), 32'hBEEF);
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0777, 16'h0);
    tick();
    check("b2b_alu_out", 32'(mem_alu_out), 32'h0777);
    check("b2b_regWrite", 32'(mem_regWrite), 32'h1);

    // Flush on capture kills the load; flush during a request is ignored
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 16'h0050, 16'h0);
    flush = 1'b1;
    tick();
    check("fl_req", 32'(dmem_req), 32'h0);
    check("fl_regWrite", 32'(mem_regWrite), 32'h0);
    flush = 1'b0;
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 16'h0060, 16'h0);
    tick();
    flush = 1'b1;
    tick();
    dmem_ack = 1'b1; dmem_rdata = 16'h1357;
    tick();
    dmem_ack = 1'b0; flush = 1'b0;
    check("flw_read_data", 32'(mem_read_data), 32'h1357);
    check("flw_regWrite", 32'(mem_regWrite), 32'h1);
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Timeout: no ack for TIMEOUT request cycles
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0070, 16'h0);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (TIMEOUT - 1) tick();
    check("to_last_req", 32'(dmem_req), 32'h1);
    tick();
    check("to_err", 32'(mem_err), 32'h1);
    check("to_regWrite", 32'(mem_regWrite), 32'h0);
    check("to_req", 32'(dmem_req), 32'h0);
    check("to_read_data", 32'(mem_read_data), 32'h1357);
    tick();
    check("to_err_clear", 32'(mem_err), 32'h0);

    // Odd address
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 16'h0041, 16'h0);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
`ifdef MEM_ALIGN_CHECK_EN
    check("al_req", 32'(dmem_req), 32'h0);
    check("al_err", 32'(mem_err), 32'h1);
    check("al_regWrite", 32'(mem_regWrite), 32'h0);
    tick();
    check("al_err_clear", 32'(mem_err), 32'h0);
`else
    check("al_req", 32'(dmem_req), 32'h1);
    check("al_addr", 32'(dmem_addr), 32'h0041);
    dmem_ack = 1'b1; dmem_rdata = 16'h2468;
    tick();
    dmem_ack = 1'b0;
    check("al_read_data", 32'(mem_read_data), 32'h2468);
    check("al_err", 32'(mem_err), 32'h0);
`endif

    // Reset during an outstanding request drops it immediately
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0080, 16'h0);
    tick();
    check("rw_req_before", 32'(dmem_req), 32'h1);
    model_on = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rw_req", 32'(dmem_req), 32'h0);
    check("rw_stall", 32'(stall_out), 32'h0);
    check("rw_read_data", 32'(mem_read_data), 32'h0);
    model_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    model_on = 1'b1;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      tick();
    end
    check("rand_requests_seen", 32'(n_req > 100), 32'h1);

    model_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
